// File: rtl/jtframe_sdram_rr_arb.sv
// rtl/jtframe_sdram_rr_arb.sv - round-robin arbiter sharing one SDRAM bank read port between N clients
//
// Purpose: grants one client at a time (one outstanding transaction), registers
// its address towards the SDRAM controller and routes the controller's ack/rdy
// handshakes back to the grantee only. Read data is broadcast elsewhere.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cl_req      per-client request level, held until that client's ack
//   cl_addr     packed client addresses, client i at [i*SDRAMW +: SDRAMW]
//   cl_ack      one-hot, combinational: sdram_ack routed to the grantee
//   cl_rdy      one-hot, combinational: data_rdy routed to the grantee
//   grant       one-hot current bank owner, 0 when idle
//   sdram_req   registered request to the SDRAM controller
//   sdram_addr  registered address, loaded on the grant edge only
//   sdram_ack   controller accepted the request (1-cycle pulse)
//   data_rdy    read data valid (1-cycle pulse)
//   spurious    1-cycle pulse after a data_rdy seen while idle
//   wdog_err    1-cycle pulse on watchdog abort
//
// Optional feature: define JTFRAME_ARB_WDOG_EN to enable the transaction
// watchdog (timeout 2**WDOGW-1 cycles). Without it wdog_err is tied 0 and a
// transaction waits indefinitely for ack/rdy.

module jtframe_sdram_rr_arb #(
    parameter int N      = 4,
    parameter int SDRAMW = 22,
    parameter int WDOGW  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          cl_req,
    input  logic [N*SDRAMW-1:0]   cl_addr,
    output logic [N-1:0]          cl_ack,
    output logic [N-1:0]          cl_rdy,
    output logic [N-1:0]          grant,
    output logic                  sdram_req,
    output logic [SDRAMW-1:0]     sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    output logic                  spurious,
    output logic                  wdog_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        grant_q, grant_d;
    logic                sdram_req_q, sdram_req_d;
    logic [SDRAMW-1:0]   sdram_addr_q, sdram_addr_d;
    logic [IW-1:0]       last_q, last_d;
    logic                spurious_q, spurious_d;

    logic [IW-1:0]       pick;
    logic                wdog_timeout;
    logic                abort;

    // Scan clients starting just after the last grantee, wrapping modulo N.
    always_comb begin
        logic found;
        int   idx_i;
        logic [IW-1:0] idx;
        pick  = last_q;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_i = (int'(last_q) + k) % N;
            idx   = IW'(idx_i);
            if (!found && cl_req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // A completing handshake in the same cycle wins over the watchdog.
    assign abort = wdog_timeout &&
                   (((state_q == ST_REQ) && !sdram_ack) ||
                    ((state_q == ST_DATA) && !data_rdy));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            last_q       <= IW'(N - 1);
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            last_q       <= last_d;
            spurious_q   <= spurious_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|cl_req) state_d = ST_REQ;
            ST_REQ: begin
                if (sdram_ack)  state_d = data_rdy ? ST_IDLE : ST_DATA;
                else if (abort) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (data_rdy)   state_d = ST_IDLE;
                else if (abort) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered datapath updates
    always_comb begin
        grant_d      = grant_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        last_d       = last_q;
        spurious_d   = (state_q == ST_IDLE) && data_rdy;
        case (state_q)
            ST_IDLE: begin
                if (|cl_req) begin
                    grant_d      = {{(N-1){1'b0}}, 1'b1} << pick;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = cl_addr[pick*SDRAMW +: SDRAMW];
                    last_d       = pick;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    if (data_rdy) grant_d = '0;
                end else if (abort) begin
                    sdram_req_d = 1'b0;
                    grant_d     = '0;
                end
            end
            ST_DATA: begin
                if (data_rdy || abort) grant_d = '0;
            end
            default: begin
                grant_d     = '0;
                sdram_req_d = 1'b0;
            end
        endcase
    end

    // Combinational handshake routing to the grantee
    always_comb begin
        cl_ack = '0;
        cl_rdy = '0;
        if (state_q == ST_REQ && sdram_ack) begin
            cl_ack = grant_q;
            if (data_rdy) cl_rdy = grant_q;
        end
        if (state_q == ST_DATA && data_rdy) cl_rdy = grant_q;
    end

`ifdef JTFRAME_ARB_WDOG_EN
    logic [WDOGW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             wdog_err_q, wdog_err_d;

    // Counter is held at zero while idle, so it starts from zero on every grant.
    // Aborting when it is one short of the limit makes the abort edge the one
    // on which the count reaches 2**WDOGW-1.
    always_comb begin
        wdog_cnt_d = (state_q == ST_IDLE) ? '0 : wdog_cnt_q + 1'b1;
        wdog_err_d = abort;
    end

    assign wdog_timeout = (state_q != ST_IDLE) &&
                          (wdog_cnt_q == WDOGW'((2 ** WDOGW) - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    // WDOGW only sizes the watchdog; this constant-false compare keeps it referenced.
    assign wdog_timeout = (WDOGW < 0);
    assign wdog_err     = 1'b0;
`endif

    assign grant      = grant_q;
    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign spurious   = spurious_q;

endmodule

// File: tb/tb_jtframe_sdram_rr_arb.sv
// tb/tb_jtframe_sdram_rr_arb.sv - self-checking bench for jtframe_sdram_rr_arb

module tb_jtframe_sdram_rr_arb;

    localparam int N      = 4;
    localparam int SDRAMW = 22;
    localparam int WDOGW  = 4;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         cl_req;
    logic [N*SDRAMW-1:0]  cl_addr;
    logic [N-1:0]         cl_ack;
    logic [N-1:0]         cl_rdy;
    logic [N-1:0]         grant;
    logic                 sdram_req;
    logic [SDRAMW-1:0]    sdram_addr;
    logic                 sdram_ack;
    logic                 data_rdy;
    logic                 spurious;
    logic                 wdog_err;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic [SDRAMW-1:0] addr_tab [N];

    jtframe_sdram_rr_arb #(.N(N), .SDRAMW(SDRAMW), .WDOGW(WDOGW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cl_req     (cl_req),
        .cl_addr    (cl_addr),
        .cl_ack     (cl_ack),
        .cl_rdy     (cl_rdy),
        .grant      (grant),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .spurious   (spurious),
        .wdog_err   (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One complete transaction: wait for sdram_req, pop the expected grantee,
    // ack ack_dly cycles later, rdy rdy_dly cycles after ack (0 = same cycle).
    task automatic txn(input int ack_dly, input int rdy_dly);
        int n = 0;
        int c;
        logic [N-1:0] g;
        while (sdram_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_wait", (n < 20), 1);
        if (n >= 20) return;
        chk("sb_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        c = exp_q.pop_front();
        g = N'(1) << c;
        chk("grant", grant, g);
        chk("addr", sdram_addr, addr_tab[c]);
        for (int i = 0; i < ack_dly; i++) begin
            step();
            chk("req_hold", sdram_req, 1);
        end
        sdram_ack = 1'b1;
        if (rdy_dly == 0) data_rdy = 1'b1;
        #1;
        chk("cl_ack", cl_ack, g);
        chk("cl_rdy_at_ack", cl_rdy, (rdy_dly == 0) ? g : '0);
        step();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        #1;
        chk("req_fall", sdram_req, 0);
        if (rdy_dly > 0) begin
            for (int i = 1; i < rdy_dly; i++) step();
            data_rdy = 1'b1;
            #1;
            chk("cl_rdy", cl_rdy, g);
            chk("cl_ack_in_data", cl_ack, 0);
            step();
            data_rdy = 1'b0;
            #1;
        end
        chk("grant_idle", grant, 0);
        chk("req_gap", sdram_req, 0);
    endtask

    initial begin
        int n;
        int c;
        addr_tab[0] = 22'h0A5A5;
        addr_tab[1] = 22'h1234C;
        addr_tab[2] = 22'h3F00F;
        addr_tab[3] = 22'h2ABCD;
        for (int i = 0; i < N; i++) cl_addr[i*SDRAMW +: SDRAMW] = addr_tab[i];
        rst_n     = 1'b0;
        cl_req    = '0;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        repeat (3) step();

        chk("rst_grant", grant, 0);
        chk("rst_req", sdram_req, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_spurious", spurious, 0);
        chk("rst_wdog", wdog_err, 0);
        chk("rst_ack", cl_ack, 0);
        rst_n = 1'b1;
        step();

        // All clients requesting: strict rotation starting at client 0
        cl_req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int i = 0; i < 5; i++) txn(2, 4);
        cl_req = '0;

        // Single requester
        step();
        cl_req = 4'b0100;
        exp_q.push_back(2);
        txn(1, 3);
        cl_req = '0;

        // ack and rdy together, then back-to-back with a one-cycle gap
        step();
        cl_req = 4'b1000;
        exp_q.push_back(3); exp_q.push_back(3);
        txn(1, 0);
        step();
        chk("req_after_gap", sdram_req, 1);
        txn(0, 0);
        cl_req = '0;

        // Two contenders alternate (last grantee was 3)
        step();
        cl_req = 4'b1010;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1);
        for (int i = 0; i < 3; i++) txn(1, 1);
        cl_req = '0;

        // Spurious data_rdy while idle
        step();
        data_rdy = 1'b1;
        #1;
        chk("spur_no_rdy", cl_rdy, 0);
        step();
        data_rdy = 1'b0;
        #1;
        chk("spur_pulse", spurious, 1);
        chk("spur_grant", grant, 0);
        step();
        chk("spur_clear", spurious, 0);

        // Reset while in DATA with grant=0010
        cl_req = 4'b0010;
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("rst_req_wait", (n < 20), 1);
        chk("rst_pre_grant", grant, 4'b0010);
        step();
        sdram_ack = 1'b1;
        #1;
        chk("rst_pre_ack", cl_ack, 4'b0010);
        step();
        sdram_ack = 1'b0;
        #1;
        chk("rst_in_data", grant, 4'b0010);
        step();
        rst_n  = 1'b0;
        cl_req = '0;
        #1;
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_req", sdram_req, 0);
        step();
        rst_n    = 1'b1;
        data_rdy = 1'b1;
        #1;
        chk("late_rdy_no_route", cl_rdy, 0);
        step();
        data_rdy = 1'b0;
        #1;
        chk("late_rdy_spurious", spurious, 1);
        cl_req = 4'b1111;
        exp_q.push_back(0);
        txn(1, 1);
        cl_req = '0;

`ifdef JTFRAME_ARB_WDOG_EN
        // No ack: watchdog aborts 15 cycles after grant, client re-granted
        step();
        cl_req = 4'b0100;
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("wd_req_wait", (n < 20), 1);
        c = 0;
        while (wdog_err !== 1'b1 && c < 40) begin
            step();
            c++;
        end
        chk("wd_latency", c, 15);
        chk("wd_grant_drop", grant, 0);
        chk("wd_req_drop", sdram_req, 0);
        chk("wd_no_ack", cl_ack, 0);
        step();
        chk("wd_pulse_end", wdog_err, 0);
        exp_q.push_back(2);
        txn(1, 1);
        cl_req = '0;
`else
        c = 0;
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
